sub_seq: RTL and testbench

SUB_SEQ -- requirements
Module: sub_seq

---
 rtl/sub_seq.sv | 81 ++++++++
 tb/tb_sub_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_seq.sv
// Sequential 32-bit subtractor: one operand pair at a time, processed as two 16-bit
// slices with a valid/ready handshake on each side.
module sub_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] diff,
   output logic        borrow,
   output logic        ovf
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] a_q, b_q;
   logic        lo_borrow;
   logic [16:0] lo_sub, hi_sub;

   // The 17th bit of each slice subtraction is that slice's borrow out.
   assign lo_sub = {1'b0, a_q[15:0]} - {1'b0, b_q[15:0]};
   assign hi_sub = {1'b0, a_q[31:16]} - {1'b0, b_q[31:16]} - {16'b0, lo_borrow};

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = LO;
         end
         LO:   state_nxt = HI;
         HI:   state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
      endcase
   end

   // Result registers are only written in LO/HI, so they keep the last result
   // through DONE and afterwards until the next transaction overwrites them.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q       <= '0;
         b_q       <= '0;
         lo_borrow <= 1'b0;
         diff      <= '0;
         borrow    <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q <= a;
               b_q <= b;
            end
            LO: begin
               diff[15:0] <= lo_sub[15:0];
               lo_borrow  <= lo_sub[16];
            end
            HI: begin
               diff[31:16] <= hi_sub[15:0];
               borrow      <= hi_sub[16];
               ovf         <= (a_q[31] != b_q[31]) && (hi_sub[15] != a_q[31]);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sub_seq.sv
// Scoreboard bench for sub_seq: expected results are queued on acceptance and
// popped when the DUT presents a result.
module tb_sub_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        borrow;
   logic        ovf;

   typedef struct packed {
      logic [31:0] d;
      logic        br;
      logic        ov;
   } res_t;

   res_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   sub_seq dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow(borrow), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
      res_t        r;
      logic [32:0] s;
      r.d  = x - y;
      r.br = (x < y);
      s    = {x[31], x} - {y[31], y};
      r.ov = (s[32] != s[31]);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive an operand pair until it is accepted, then scramble the inputs.
   task automatic send(input logic [31:0] x, input logic [31:0] y);
      int n = 0;
      in_valid = 1'b1;
      a = x;
      b = y;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      n_cmp++;
      if (!in_ready) begin
         n_err++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end
      tick();
      q.push_back(model(x, y));
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      tick(); tick();
      reset = 1'b0;
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_hs: in_ready/out_valid=%b required 10", {in_ready, out_valid});
      end
      n_cmp++;
      if ({diff, borrow, ovf} !== 34'h0) begin
         n_err++;
         $display("FAIL reset_res: diff=%h borrow=%b ovf=%b required 0/0/0", diff, borrow, ovf);
      end
   endtask

   task automatic test_basic();
      int   n = 0;
      res_t e;
      out_ready = 1'b1;
      send(32'h5, 32'h3);
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      n_cmp++;
      if (n !== 2 || !out_valid) begin
         n_err++;
         $display("FAIL basic_latency: cycles=%0d required 2", n);
      end
      e = q.pop_front();
      n_cmp++;
      if ({diff, borrow, ovf} !== e || e !== {32'h2, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL basic_result: %h/%b/%b required 00000002/0/0", diff, borrow, ovf);
      end
      tick();
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10 || diff !== 32'h2) begin
         n_err++;
         $display("FAIL basic_retain: rdy/vld=%b diff=%h required 10 00000002",
                  {in_ready, out_valid}, diff);
      end
   endtask

   task automatic test_vectors();
      logic [31:0] va[5] = '{32'h00010000, 32'h0, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
      logic [31:0] vb[5] = '{32'h1, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         int   n = 0;
         res_t e;
         send(va[i], vb[i]);
         while (!out_valid && n < 10) begin
            tick();
            n++;
         end
         e = q.pop_front();
         n_cmp++;
         if (!out_valid || {diff, borrow, ovf} !== e) begin
            n_err++;
            $display("FAIL vector_%0d: vld=%b %h/%b/%b required %h/%b/%b",
                     i, out_valid, diff, borrow, ovf, e.d, e.br, e.ov);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int   n = 0;
      res_t e;
      out_ready = 1'b0;
      send(32'h64, 32'hA);
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      e = q.pop_front();
      // Offer another pair while stalled; it must not be taken.
      in_valid = 1'b1;
      a = 32'h1234;
      b = 32'h1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (!out_valid || in_ready || diff !== 32'h5A || {diff, borrow, ovf} !== e) begin
            n_err++;
            $display("FAIL bp_hold_%0d: vld=%b rdy=%b diff=%h required 1 0 0000005a",
                     i, out_valid, in_ready, diff);
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL bp_release: rdy/vld=%b required 10", {in_ready, out_valid});
      end
   endtask

   task automatic test_back_to_back();
      int cyc = 0;
      int last = -1;
      int acc = 0;
      int n = 0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom;
         if (out_valid) begin
            res_t e = q.pop_front();
            n_cmp++;
            if ({diff, borrow, ovf} !== e) begin
               n_err++;
               $display("FAIL b2b_result: %h/%b/%b required %h/%b/%b",
                        diff, borrow, ovf, e.d, e.br, e.ov);
            end
         end
         if (in_ready) begin
            q.push_back(model(a, b));
            if (last >= 0) begin
               n_cmp++;
               if (cyc - last !== 4) begin
                  n_err++;
                  $display("FAIL b2b_gap: gap=%0d required 4", cyc - last);
               end
            end
            last = cyc;
            acc++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      while (q.size() > 0 && n < 20) begin
         if (out_valid) begin
            res_t e = q.pop_front();
            n_cmp++;
            if ({diff, borrow, ovf} !== e) begin
               n_err++;
               $display("FAIL b2b_drain: %h/%b/%b required %h/%b/%b",
                        diff, borrow, ovf, e.d, e.br, e.ov);
            end
         end
         tick();
         n++;
      end
      n_cmp++;
      if (q.size() !== 0 || acc !== 10) begin
         n_err++;
         $display("FAIL b2b_count: accepted=%0d left=%0d required 10 0", acc, q.size());
      end
      tick();
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      out_ready = 1'b1;
      send(32'hDEAD0000, 32'h00001111);
      tick();                         // now in HI
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q.delete();
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10 || diff !== 32'h0 || borrow !== 1'b0 || ovf !== 1'b0) begin
         n_err++;
         $display("FAIL rst_hi: rdy/vld=%b diff=%h required 10 00000000",
                  {in_ready, out_valid}, diff);
      end
      for (int i = 0; i < 6; i++) begin
         if (out_valid) seen++;
         tick();
      end
      n_cmp++;
      if (seen !== 0) begin
         n_err++;
         $display("FAIL rst_no_result: out_valid cycles=%0d required 0", seen);
      end
      // Reset beats in_valid on the same edge.
      in_valid = 1'b1;
      a = 32'h9;
      b = 32'h2;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      in_valid = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_priority: in_ready=%b required 1", in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
